// File: rtl/bufid_dispatch_arbiter.sv
// -----------------------------------------------------------------------------
// bufid_dispatch_arbiter
//
// Shares one show-ahead free-bufid FIFO among PORT_NUM receive processes
// (the host receive path and the network receive ports). A round-robin
// arbiter picks one eligible requester, pops a bufid and offers it on that
// port's bufid/wr/ack handshake. When the free pool falls to the low-water
// threshold, only ports in iv_priority_mask are eligible.
//
// Optional feature (macro BUFID_OFFER_TIMEOUT_EN): an unanswered offer is
// withdrawn after TIMEOUT_CYC cycles. The bufid is kept and re-offered to
// the next winner without another FIFO pop.
//
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   iv_cfg_finish               dispatch enabled when non-zero
//   iv_fifo_bufid/i_fifo_empty  head and empty flag of the free-bufid FIFO
//   o_fifo_rd                   one-cycle pop strobe (same cycle as grant)
//   iv_free_bufid_fifo_rdusedw  FIFO occupancy
//   iv_low_threshold            reserve threshold (occupancy <= threshold)
//   iv_priority_mask            ports still eligible under the reserve
//   iv_bufid_req                level request per port
//   ov_bufid/ov_bufid_wr        offered bufid and one-hot offer valid
//   iv_bufid_ack                per-port accept
//   o_grant_pulse               one pulse per accepted bufid
//   o_reserve_block_pulse       a request is being masked by the reserve
//   arb_state                   FSM state for debug
// -----------------------------------------------------------------------------
module bufid_dispatch_arbiter #(
  parameter int PORT_NUM    = 8,
  parameter int BUFID_W     = 9,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [1:0]          iv_cfg_finish,
  input  logic [BUFID_W-1:0]  iv_fifo_bufid,
  input  logic                i_fifo_empty,
  output logic                o_fifo_rd,
  input  logic [8:0]          iv_free_bufid_fifo_rdusedw,
  input  logic [8:0]          iv_low_threshold,
  input  logic [PORT_NUM-1:0] iv_priority_mask,
  input  logic [PORT_NUM-1:0] iv_bufid_req,
  output logic [BUFID_W-1:0]  ov_bufid,
  output logic [PORT_NUM-1:0] ov_bufid_wr,
  input  logic [PORT_NUM-1:0] iv_bufid_ack,
  output logic                o_grant_pulse,
  output logic                o_reserve_block_pulse,
  output logic [1:0]          arb_state
);

  localparam int IDX_W = $clog2(PORT_NUM);

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    OFFER_S = 2'd1
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [IDX_W-1:0]    winner_q, winner_d;
  logic                hold_q, hold_d;
  logic [BUFID_W-1:0]  bufid_q, bufid_d;
  logic [PORT_NUM-1:0] wr_q, wr_d;
  logic                grant_pulse_q, grant_pulse_d;

  logic                reserve_s;
  logic [PORT_NUM-1:0] elig_s;
  logic                found_s;
  logic [IDX_W-1:0]    win_s;
  logic                grant_s;
  logic                fifo_rd_s;
  logic                reserve_block_s;

`ifdef BUFID_OFFER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Reserve condition: equality with the threshold already counts as low.
  assign reserve_s = (iv_free_bufid_fifo_rdusedw <= iv_low_threshold);
  assign elig_s    = iv_bufid_req & (reserve_s ? iv_priority_mask : {PORT_NUM{1'b1}});

  // Round-robin search starting just after the last granted port.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    for (int i = 1; i <= PORT_NUM; i++) begin
      if (!found_s && elig_s[(int'(last_grant_q) + i) % PORT_NUM]) begin
        found_s = 1'b1;
        win_s   = IDX_W'((int'(last_grant_q) + i) % PORT_NUM);
      end else begin
        found_s = found_s;
      end
    end
  end

  // A held bufid (after a timeout) can be granted even with the FIFO empty.
  assign grant_s = (iv_cfg_finish != 2'b00) && found_s && (hold_q || !i_fifo_empty);

  // Next-state, offer registers and same-cycle pop / reserve strobes.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    winner_d        = winner_q;
    hold_d          = hold_q;
    bufid_d         = bufid_q;
    wr_d            = wr_q;
    grant_pulse_d   = 1'b0;
    fifo_rd_s       = 1'b0;
    reserve_block_s = 1'b0;
`ifdef BUFID_OFFER_TIMEOUT_EN
    cnt_d           = '0;
`endif
    case (state_q)
      IDLE_S: begin
        reserve_block_s = reserve_s && |(iv_bufid_req & ~iv_priority_mask);
        if (grant_s) begin
          winner_d = win_s;
          wr_d     = {{(PORT_NUM-1){1'b0}}, 1'b1} << win_s;
          state_d  = OFFER_S;
          if (!hold_q) begin
            fifo_rd_s = 1'b1;
            bufid_d   = iv_fifo_bufid;
          end else begin
            bufid_d   = bufid_q;
          end
        end else begin
          state_d = IDLE_S;
        end
      end
      OFFER_S: begin
        // Only the winner's ack matters; an ack on the timeout cycle wins.
        if (iv_bufid_ack[winner_q]) begin
          wr_d          = '0;
          hold_d        = 1'b0;
          last_grant_d  = winner_q;
          grant_pulse_d = 1'b1;
          state_d       = IDLE_S;
        end
`ifdef BUFID_OFFER_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          wr_d         = '0;
          hold_d       = 1'b1;
          last_grant_d = winner_q;
          state_d      = IDLE_S;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        else begin
          state_d = OFFER_S;
        end
`endif
      end
      default: begin
        wr_d    = '0;
        state_d = IDLE_S;
      end
    endcase
  end

  // State and offer registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE_S;
      last_grant_q  <= IDX_W'(PORT_NUM - 1);
      winner_q      <= '0;
      hold_q        <= 1'b0;
      bufid_q       <= '0;
      wr_q          <= '0;
      grant_pulse_q <= 1'b0;
`ifdef BUFID_OFFER_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      winner_q      <= winner_d;
      hold_q        <= hold_d;
      bufid_q       <= bufid_d;
      wr_q          <= wr_d;
      grant_pulse_q <= grant_pulse_d;
`ifdef BUFID_OFFER_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign o_fifo_rd             = fifo_rd_s;
  assign o_reserve_block_pulse = reserve_block_s;
  assign ov_bufid              = bufid_q;
  assign ov_bufid_wr           = wr_q;
  assign o_grant_pulse         = grant_pulse_q;
  assign arb_state             = state_q;

endmodule

// File: tb/tb_bufid_dispatch_arbiter.sv
// Directed testbench for bufid_dispatch_arbiter (PORT_NUM=8, BUFID_W=9).
module tb_bufid_dispatch_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] cfg_finish;
  logic [8:0] fifo_bufid;
  logic       fifo_empty;
  logic       fifo_rd;
  logic [8:0] rdusedw;
  logic [8:0] low_thr;
  logic [7:0] prio_mask;
  logic [7:0] req;
  logic [8:0] bufid;
  logic [7:0] wr;
  logic [7:0] ack;
  logic       grant_pulse;
  logic       reserve_pulse;
  logic [1:0] st;

  // Free-bufid FIFO model (show-ahead).
  logic [8:0] fifo_mem [0:63];
  int         rd_ptr = 0;
  int         fill = 64;
  logic       force_empty = 1'b0;
  int         cyc_cnt = 0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign fifo_bufid = fifo_mem[rd_ptr % 64];
  assign fifo_empty = force_empty || (rd_ptr >= fill);

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (fifo_rd) rd_ptr <= rd_ptr + 1;
  end

  bufid_dispatch_arbiter #(.PORT_NUM(8), .BUFID_W(9), .TIMEOUT_CYC(64)) dut (
    .i_clk                      (clk),
    .i_rst_n                    (rst_n),
    .iv_cfg_finish              (cfg_finish),
    .iv_fifo_bufid              (fifo_bufid),
    .i_fifo_empty               (fifo_empty),
    .o_fifo_rd                  (fifo_rd),
    .iv_free_bufid_fifo_rdusedw (rdusedw),
    .iv_low_threshold           (low_thr),
    .iv_priority_mask           (prio_mask),
    .iv_bufid_req               (req),
    .ov_bufid                   (bufid),
    .ov_bufid_wr                (wr),
    .iv_bufid_ack               (ack),
    .o_grant_pulse              (grant_pulse),
    .o_reserve_block_pulse      (reserve_pulse),
    .arb_state                  (st)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req        = 8'h00;
    ack        = 8'h00;
    cfg_finish = 2'b00;
    rdusedw    = 9'd100;
    low_thr    = 9'd0;
    prio_mask  = 8'h00;
    mid();
    tick();
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for an offer; ends on a negedge.
  task automatic wait_wr(output int seen);
    int n;
    n = 0;
    mid();
    while (wr == 8'h00 && n < 20) begin
      tick();
      mid();
      n++;
    end
    seen = cyc_cnt;
  endtask

  initial begin
    int t, tprev, start, n;
    logic [7:0] exp_port;
    logic [8:0] held;
    for (int i = 0; i < 64; i++) fifo_mem[i] = 9'((i * 7 + 5) % 512);
    t = 0; tprev = 0;

    // Reset values
    rst_n = 1'b0; req = 8'h00; ack = 8'h00; cfg_finish = 2'b00;
    rdusedw = 9'd100; low_thr = 9'd0; prio_mask = 8'h00;
    mid();
    check("rst_wr", wr, 8'h00);
    check("rst_bufid", bufid, 9'h000);
    check("rst_rd", fifo_rd, 1'b0);
    check("rst_gp", grant_pulse, 1'b0);
    check("rst_rb", reserve_pulse, 1'b0);
    check("rst_state", st, 2'd0);
    tick();
    rst_n = 1'b1;

    // 1: single grant, latency and ack
    cfg_finish = 2'b11;
    req = 8'h01;
    mid();
    check("t1_rd", fifo_rd, 1'b1);
    check("t1_wr_n", wr, 8'h00);
    tick(); mid();
    check("t1_bufid", bufid, 9'h005);
    check("t1_wr", wr, 8'h01);
    check("t1_state", st, 2'd1);
    check("t1_rd_off", fifo_rd, 1'b0);
    tick(); ack = 8'h01; mid();
    check("t1_wr_m", wr, 8'h01);
    check("t1_gp_m", grant_pulse, 1'b0);
    tick(); ack = 8'h00; req = 8'h00; mid();
    check("t1_wr_m1", wr, 8'h00);
    check("t1_gp_m1", grant_pulse, 1'b1);
    check("t1_state_m1", st, 2'd0);
    tick(); mid();
    check("t1_gp_m2", grant_pulse, 1'b0);
    tick();

    // 2: round robin over all ports, FIFO order, 3-cycle cadence
    do_reset();
    cfg_finish = 2'b11;
    req = 8'hFF;
    start = rd_ptr;
    for (int g = 0; g < 9; g++) begin
      exp_port = 8'h01 << (g % 8);
      wait_wr(t);
      check("t2_port", wr, exp_port);
      check("t2_bufid", bufid, fifo_mem[start + g]);
      if (g > 0) check("t2_gap", t - tprev, 3);
      tprev = t;
      tick(); ack = exp_port; mid();
      tick(); ack = 8'h00;
    end
    req = 8'h00;
    mid();
    check("t2_pops", rd_ptr - start, 9);
    tick();

    // 3: low-water reserve
    do_reset();
    cfg_finish = 2'b11;
    rdusedw = 9'd4; low_thr = 9'd4; prio_mask = 8'h01; req = 8'h06;
    mid();
    check("t3_rb", reserve_pulse, 1'b1);
    check("t3_rd_blk", fifo_rd, 1'b0);
    tick(); mid();
    check("t3_wr_blk", wr, 8'h00);
    check("t3_rb2", reserve_pulse, 1'b1);
    tick(); rdusedw = 9'd5; mid();
    check("t3_rd", fifo_rd, 1'b1);
    check("t3_rb_off", reserve_pulse, 1'b0);
    tick(); mid();
    check("t3_wr", wr, 8'h02);
    tick(); ack = 8'h02; mid();
    tick(); ack = 8'h00; req = 8'h00; mid();
    check("t3_gp", grant_pulse, 1'b1);
    tick();

    // 4: empty FIFO never popped
    do_reset();
    cfg_finish = 2'b11;
    force_empty = 1'b1;
    req = 8'h01;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("t4_rd_empty", fifo_rd, 1'b0);
      check("t4_wr_empty", wr, 8'h00);
      tick();
    end
    force_empty = 1'b0;
    mid();
    check("t4_rd", fifo_rd, 1'b1);
    tick(); mid();
    check("t4_wr", wr, 8'h01);
    tick(); ack = 8'h01; mid();
    tick(); ack = 8'h00; req = 8'h00; mid();
    check("t4_gp", grant_pulse, 1'b1);
    tick();

    // 5: foreign ack and dropped request do not disturb the offer
    do_reset();
    cfg_finish = 2'b11;
    req = 8'h04;
    start = rd_ptr;
    wait_wr(t);
    check("t5_wr", wr, 8'h04);
    check("t5_bufid", bufid, fifo_mem[start]);
    tick(); ack = 8'h08; req = 8'h00;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("t5_hold_wr", wr, 8'h04);
      check("t5_hold_bufid", bufid, fifo_mem[start]);
      check("t5_hold_state", st, 2'd1);
      check("t5_hold_gp", grant_pulse, 1'b0);
      tick();
    end
    ack = 8'h04;
    mid();
    check("t5_wr_m", wr, 8'h04);
    tick(); ack = 8'h00; mid();
    check("t5_wr_done", wr, 8'h00);
    check("t5_gp", grant_pulse, 1'b1);
    tick();

`ifdef BUFID_OFFER_TIMEOUT_EN
    // 6: timeout, held bufid re-offered without a pop
    do_reset();
    cfg_finish = 2'b11;
    req = 8'h06;
    start = rd_ptr;
    wait_wr(t);
    check("t6_wr1", wr, 8'h02);
    check("t6_bufid1", bufid, fifo_mem[start]);
    held = fifo_mem[start];
    n = 1;
    while (wr == 8'h02 && n < 200) begin
      tick(); mid();
      if (wr == 8'h02) n++;
      else break;
    end
    check("t6_offer_len", n, 64);
    check("t6_wr_off", wr, 8'h00);
    check("t6_no_pop", fifo_rd, 1'b0);
    check("t6_state", st, 2'd0);
    check("t6_gp", grant_pulse, 1'b0);
    tick(); mid();
    check("t6_wr2", wr, 8'h04);
    check("t6_bufid2", bufid, held);
    check("t6_pops", rd_ptr - start, 1);
    tick(); ack = 8'h04; req = 8'h00; mid();
    tick(); ack = 8'h00; mid();
    check("t6_gp2", grant_pulse, 1'b1);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bufid_dispatch_arbiter.md
Name: bufid_dispatch_arbiter

Overview:
- Shares the single free-bufid FIFO (show-ahead) among PORT_NUM receive processes: the host receive path and the network receive ports.
- Round-robin arbitration picks one requester, pops one bufid, and offers it on that port's bufid/wr/ack handshake.
- A low-water reserve restricts grants to priority ports when the free pool is nearly exhausted.
- Sits between the free-bufid FIFO and every packet_map_dispatch-style consumer.

Parameters:
PORT_NUM, 8, number of requesting ports (≥2).
BUFID_W, 9, bufid width.
TIMEOUT_CYC, 64, offer timeout in cycles (used only with the optional feature).

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
iv_cfg_finish  in  2  dispatch enabled when != 2'b00
iv_fifo_bufid  in  BUFID_W  head of free-bufid FIFO (show-ahead)
i_fifo_empty  in  1  free-bufid FIFO empty
o_fifo_rd  out  1  one-cycle pop strobe
iv_free_bufid_fifo_rdusedw  in  9  free-bufid FIFO occupancy
iv_low_threshold  in  9  reserve threshold
iv_priority_mask  in  PORT_NUM  ports still eligible below threshold
iv_bufid_req  in  PORT_NUM  level request per port
ov_bufid  out  BUFID_W  offered bufid
ov_bufid_wr  out  PORT_NUM  one-hot offer valid
iv_bufid_ack  in  PORT_NUM  per-port accept
o_grant_pulse  out  1  one-cycle pulse per accepted bufid
o_reserve_block_pulse  out  1  pulse when a request is masked by the reserve
arb_state  out  2  FSM state for debug

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0; state IDLE_S; last_grant=PORT_NUM-1 (so port 0 is searched first); held-bufid valid flag r_hold=0.
- Eligibility: elig = iv_bufid_req & (rdusedw <= iv_low_threshold ? iv_priority_mask : all-ones).
  - rdusedw equal to the threshold counts as the reserve condition.
  - o_reserve_block_pulse is asserted in IDLE_S when iv_bufid_req has bits masked off by the reserve.
- Round-robin search order: last_grant+1 … PORT_NUM-1, 0 … last_grant. The first eligible port wins.
- FSM states: IDLE_S=0, OFFER_S=1, (2, 3 unused → IDLE_S).
- IDLE_S transitions:
  - Grant condition: iv_cfg_finish!=0, elig!=0, and (r_hold=1 or i_fifo_empty=0).
  - On grant, in the same cycle, register the winner index.
  - If r_hold=0: assert o_fifo_rd for 1 cycle and latch iv_fifo_bufid into ov_bufid.
  - If r_hold=1: reuse the held ov_bufid and do not pop.
  - Set ov_bufid_wr one-hot for the winner and go to OFFER_S.
  - Result: req sampled in cycle N gives wr high in cycle N+1.
  - FIFO empty with r_hold=0: no pop, no grant, stay in IDLE_S.
  - The pop is never issued while the FIFO is empty.
- OFFER_S behaviour:
  - ov_bufid and ov_bufid_wr are held stable until iv_bufid_ack[winner]=1 in cycle M.
  - At M+1: wr=0, r_hold=0, last_grant=winner, o_grant_pulse=1 for one cycle, state IDLE_S.
  - The next grant is earliest at M+2.
  - Acks on non-winner ports are ignored.
  - Deassertion of the winner's req during OFFER_S does not withdraw the offer; the port must ack.
- iv_cfg_finish dropping to 0 during OFFER_S: the offer completes normally; no new grants afterwards.
- Simultaneous ack and new requests: the ack is processed first; new requests are arbitrated in the following IDLE_S cycle with the updated last_grant.
- Reset mid-offer: the offered bufid is dropped. The free pool is re-initialised by the buffer manager on reset, so no recovery is required.

Optional Feature:
- Macro BUFID_OFFER_TIMEOUT_EN.
- Defined: a counter runs in OFFER_S.
  - If no ack arrives after TIMEOUT_CYC cycles, wr is deasserted, r_hold=1 (bufid kept), last_grant=winner, and state returns to IDLE_S.
  - The next grant reuses the held bufid without a FIFO pop.
  - An ack in the same cycle as the timeout counts as accept.
- Not defined: no counter; OFFER_S waits for ack indefinitely; r_hold is always 0.

Test Plan:
1. Reset, cfg_finish=2'b11, FIFO head 9'h005, req=8'b0000_0001 → o_fifo_rd pulse at N, ov_bufid=5 and ov_bufid_wr=8'h01 at N+1; ack at M → wr=0 and o_grant_pulse at M+1.
2. req=8'hFF held, immediate acks, FIFO nonempty → grant order 0,1,…,7,0 with one grant per 3 cycles; bufids popped in FIFO order.
3. rdusedw=4, threshold=4, mask=8'h01, req=8'h06 → no grant and o_reserve_block_pulse=1; raise rdusedw to 5 → port 1 granted.
4. i_fifo_empty=1, req=8'h01 → o_fifo_rd never asserted, wr stays 0; deassert empty → grant next cycle.
5. During OFFER to port 2, assert ack on port 3 and drop req[2] → offer held and unaffected; ack[2] completes it.
6. BUFID_OFFER_TIMEOUT_EN, TIMEOUT_CYC=64, winner 1 never acks, req=8'h06 → after 64 cycles wr withdrawn; port 2 is offered the same bufid with no second o_fifo_rd.
